// File: rtl/m8_32_pkg.sv
// Shared constants for the m8_32 converter front end: FSM encodings,
// word geometry and the default filler byte.
package m8_32_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_PAD   = 2'd2
   } state_t;

   localparam int         BYTES_PER_WORD   = 4;
   localparam logic [7:0] PAD_BYTE_DEFAULT = 8'hF7;

endpackage

// File: rtl/m8_32_arbiter_rr_pick.sv
// Combinational round-robin picker: first lane set in (valid & ~exclude),
// searching upward from ptr+1 and wrapping modulo NUM_REQ.
module rr_pick
   import m8_32_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [2:0]         ptr,
   input  logic [NUM_REQ-1:0] exclude,
   output logic [2:0]         lane,
   output logic               found
);

   logic [7:0] cand;
   logic [2:0] idx;

   always_comb begin
      cand  = 8'(valid & ~exclude);
      lane  = 3'd0;
      found = 1'b0;
      idx   = 3'd0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = 3'((int'(ptr) + k) % NUM_REQ);
         if (!found && cand[idx]) begin
            found = 1'b1;
            lane  = idx;
         end
      end
   end

endmodule

// File: rtl/m8_32_arbiter.sv
// Round-robin front end sharing one m8_32 converter among NUM_REQ byte lanes in
// locked 4-byte bursts. Define M8_32_ARB_STATS_EN to add abort_cnt/word_cnt.
module m8_32_arbiter
   import m8_32_pkg::*;
#(
   parameter int         NUM_REQ   = 4,
   parameter int         STALL_MAX = 8,
   parameter logic [7:0] PAD_BYTE  = PAD_BYTE_DEFAULT
) (
   input  logic                 clk_4f,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           data_input,
   output logic                 valid_input,
   output logic [2:0]           word_lane,
   output logic                 burst_start,
   output logic                 pad_flag
`ifdef M8_32_ARB_STATS_EN
   ,
   output logic [7:0]           abort_cnt,
   output logic [15:0]          word_cnt
`endif
);

   localparam int         STALL_W   = $clog2(STALL_MAX + 1);
   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   state_t             state, state_nxt;
   logic [2:0]         owner, owner_nxt, rr_ptr, rr_ptr_nxt;
   logic [1:0]         byte_cnt, byte_cnt_nxt;
   logic [STALL_W-1:0] stall_cnt, stall_nxt;
   logic [7:0]         data_nxt;
   logic               valid_nxt, pad_nxt, start_nxt;
   logic [2:0]         lane_nxt;

   logic [7:0]         valid8;
   logic [63:0]        data64;
   logic               own_valid;
   logic [NUM_REQ-1:0] own_mask, pick_excl;
   logic [2:0]         pick_ptr, pick_lane;
   logic               pick_found;

   assign valid8    = 8'(req_valid);
   assign data64    = 64'(req_data);
   assign own_valid = valid8[owner];
   assign own_mask  = NUM_REQ'(8'd1 << owner);

   // One picker serves both IDLE arbitration and the end-of-burst handover.
   assign pick_ptr  = (state == ST_IDLE) ? rr_ptr : owner;
   assign pick_excl = (state == ST_IDLE) ? '0 : own_mask;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .valid   (req_valid),
      .ptr     (pick_ptr),
      .exclude (pick_excl),
      .lane    (pick_lane),
      .found   (pick_found)
   );

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++)
         req_ready[i] = (state == ST_BURST) && (owner == 3'(i));
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      rr_ptr_nxt   = rr_ptr;
      byte_cnt_nxt = byte_cnt;
      stall_nxt    = stall_cnt;
      data_nxt     = 8'h00;
      valid_nxt    = 1'b0;
      pad_nxt      = 1'b0;
      start_nxt    = 1'b0;
      lane_nxt     = word_lane;
      case (state)
         ST_IDLE: begin
            byte_cnt_nxt = 2'd0;
            stall_nxt    = '0;
            if (pick_found) begin
               owner_nxt = pick_lane;
               state_nxt = ST_BURST;
            end
         end
         ST_BURST: begin
            if (own_valid) begin
               data_nxt     = data64[{owner, 3'b000} +: 8];
               valid_nxt    = 1'b1;
               stall_nxt    = '0;
               byte_cnt_nxt = byte_cnt + 2'd1;
               if (byte_cnt == 2'd0) begin
                  start_nxt = 1'b1;
                  lane_nxt  = owner;
               end
               // Owner is valid here, so with no other taker it simply re-wins.
               if (byte_cnt == LAST_BYTE) begin
                  rr_ptr_nxt = owner;
                  if (pick_found) owner_nxt = pick_lane;
               end
            end else if (stall_cnt == STALL_W'(STALL_MAX - 1)) begin
               state_nxt = ST_PAD;
               stall_nxt = '0;
            end else begin
               stall_nxt = stall_cnt + STALL_W'(1);
            end
         end
         ST_PAD: begin
            data_nxt     = PAD_BYTE;
            valid_nxt    = 1'b1;
            pad_nxt      = 1'b1;
            byte_cnt_nxt = byte_cnt + 2'd1;
            if (byte_cnt == 2'd0) begin
               start_nxt = 1'b1;
               lane_nxt  = owner;
            end
            if (byte_cnt == LAST_BYTE) begin
               rr_ptr_nxt = owner;
               state_nxt  = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state       <= ST_IDLE;
         owner       <= 3'd0;
         rr_ptr      <= 3'(NUM_REQ - 1);
         byte_cnt    <= 2'd0;
         stall_cnt   <= '0;
         data_input  <= 8'h00;
         valid_input <= 1'b0;
         pad_flag    <= 1'b0;
         burst_start <= 1'b0;
         word_lane   <= 3'd0;
      end else begin
         state       <= state_nxt;
         owner       <= owner_nxt;
         rr_ptr      <= rr_ptr_nxt;
         byte_cnt    <= byte_cnt_nxt;
         stall_cnt   <= stall_nxt;
         data_input  <= data_nxt;
         valid_input <= valid_nxt;
         pad_flag    <= pad_nxt;
         burst_start <= start_nxt;
         word_lane   <= lane_nxt;
      end
   end

`ifdef M8_32_ARB_STATS_EN
   logic enter_pad, burst_done;

   assign enter_pad  = (state == ST_BURST) && (state_nxt == ST_PAD);
   assign burst_done = (((state == ST_BURST) && own_valid) || (state == ST_PAD))
                       && (byte_cnt == LAST_BYTE);

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         abort_cnt <= 8'd0;
         word_cnt  <= 16'd0;
      end else begin
         if (enter_pad && (abort_cnt != 8'hFF)) abort_cnt <= abort_cnt + 8'd1;
         if (burst_done) word_cnt <= word_cnt + 16'd1;
      end
   end
`endif

endmodule
